// File: rtl/sync_stable_capture.sv
// Purpose: qualifies a synchronized bus value once it has held unchanged for STABLE_CYCLES samples, then presents it once.
// Latency: out_valid asserts after the edge STABLE_CYCLES+1 edges past the first sample of a new value.
// Backpressure: out_valid/out_data hold until out_ready; a blocked stable value is superseded by a newer one.
// Optional: define SYNC_STABLE_CAPTURE_DROP_CNT_EN to add the drop_cnt output (superseded qualified values).
module sync_stable_capture #(
  parameter int DATA_WIDTH    = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [DATA_WIDTH-1:0] d_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] last_cap;
  logic                  first;

  logic changed;
  logic stable;
  logic fresh;
  logic can_take;
  logic capture;

  // Qualification and capture decisions, all from registered state except the change detect.
  always_comb begin
    changed  = 1'b0;
    stable   = 1'b0;
    fresh    = 1'b0;
    can_take = 1'b0;
    capture  = 1'b0;
    changed  = (d_in != d_q);
    stable   = (cnt == CNT_MAX);
    // The very first value after reset is always new, even when it equals the reset value of last_cap.
    fresh    = first || (d_q != last_cap);
    // Zero-bubble: a value may be loaded in the same edge the consumer takes the current one.
    can_take = !out_valid || out_ready;
    capture  = stable && fresh && can_take;
  end

  // Sample register: one-cycle-old copy of the input for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_in;
    end
  end

  // Run-length counter of consecutive matching samples, saturating at STABLE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (changed) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output register and duplicate-suppression state; a capture wins over the valid drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      last_cap  <= '0;
      first     <= 1'b1;
    end else if (capture) begin
      out_data  <= d_q;
      out_valid <= 1'b1;
      last_cap  <= d_q;
      first     <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
  logic dropped;

  // A qualified new value is lost when it is blocked by the consumer and the input moves on.
  always_comb begin
    dropped = 1'b0;
    dropped = stable && fresh && out_valid && !out_ready && changed;
  end

  // Saturating count of superseded qualified values.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (dropped && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_stable_capture.sv
// Bench for sync_stable_capture: directed scenarios plus a randomized run against a sample-window model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Define SYNC_STABLE_CAPTURE_DROP_CNT_EN here as for the design to exercise drop_cnt.
module tb_sync_stable_capture;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         out_ready = 1'b1;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  sync_stable_capture #(
    .DATA_WIDTH    (W),
    .STABLE_CYCLES (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the last N+1 samples since reset (reset itself counts as a 0 sample).
  // A value is qualified when all N+1 samples in the window agree.
  logic [W-1:0] win [0:N];
  int           wlen = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_last = '0;
  logic         m_first = 1'b1;
  int           m_drop = 0;
  logic         m_stable;
  logic         m_fresh;

  always_comb begin
    m_stable = (wlen >= N + 1);
    for (int i = 1; i <= N; i++) begin
      if (win[i] !== win[0]) m_stable = 1'b0;
    end
    m_fresh = m_first || (win[0] != m_last);
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N; i++) win[i] <= '0;
      wlen    <= 1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= '0;
      m_first <= 1'b1;
      m_drop  <= 0;
    end else begin
      if (m_stable && m_fresh && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_data  <= win[0];
        m_last  <= win[0];
        m_first <= 1'b0;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (m_stable && m_fresh && m_valid && !out_ready && (d_in != win[0]) && (m_drop < 255))
        m_drop <= m_drop + 1;
      win[0] <= d_in;
      for (int i = 1; i <= N; i++) win[i] <= win[i-1];
      wlen <= (wlen < N + 1) ? wlen + 1 : wlen;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_in = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b want=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%0h want=0", out_data);
    end
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_drop got=%0d want=0", drop_cnt);
    end
`endif
  endtask

  task automatic test_first_zero();
    logic exp_v;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_v = (i == 4);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== '0)) begin
        failures++;
        $display("FAIL first_zero edge=%0d valid=%0b data=%0h want valid=%0b data=0", i + 1, out_valid, out_data, exp_v);
      end
      checks++;
      if ({out_valid, out_data} !== {m_valid, m_data}) begin
        failures++;
        $display("FAIL first_zero_model valid=%0b data=%0h want valid=%0b data=%0h", out_valid, out_data, m_valid, m_data);
      end
    end
  endtask

  task automatic test_new_value();
    logic exp_v;
    d_in = W'(5);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_v = (i == 5);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== W'(5))) begin
        failures++;
        $display("FAIL new_value edge=E%0d valid=%0b data=%0h want valid=%0b data=5", i, out_valid, out_data, exp_v);
      end
      checks++;
      if ({out_valid, out_data} !== {m_valid, m_data}) begin
        failures++;
        $display("FAIL new_value_model valid=%0b data=%0h want valid=%0b data=%0h", out_valid, out_data, m_valid, m_data);
      end
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] got [$];
    int seen_valid;
    seen_valid = 0;
    // Short glitch to 7 then back to the already-delivered 5: nothing should appear.
    for (int i = 0; i < 13; i++) begin
      d_in = (i < 3) ? W'(7) : W'(5);
      tick();
      if (out_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL short_glitch valid_cycles=%0d want=0", seen_valid);
    end
    // Glitch long enough to qualify: 7 then 5 must both be delivered.
    for (int i = 0; i < 17; i++) begin
      d_in = (i < 5) ? W'(7) : W'(5);
      tick();
      if (out_valid && out_ready) got.push_back(out_data);
      checks++;
      if ({out_valid, out_data} !== {m_valid, m_data}) begin
        failures++;
        $display("FAIL glitch_model valid=%0b data=%0h want valid=%0b data=%0h", out_valid, out_data, m_valid, m_data);
      end
    end
    checks++;
    if (got.size() != 2) begin
      failures++;
      $display("FAIL long_glitch_count got=%0d want=2", got.size());
    end else begin
      checks++;
      if (got[0] !== W'(7) || got[1] !== W'(5)) begin
        failures++;
        $display("FAIL long_glitch_order got=%0h,%0h want=7,5", got[0], got[1]);
      end
    end
  endtask

  task automatic test_backpressure();
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    logic [7:0] drop0;
    drop0 = drop_cnt;
`endif
    out_ready = 1'b0;
    d_in = W'(9);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(9)) begin
      failures++;
      $display("FAIL bp_hold9 valid=%0b data=%0h want valid=1 data=9", out_valid, out_data);
    end
    d_in = W'(11);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(9)) begin
      failures++;
      $display("FAIL bp_blocked valid=%0b data=%0h want valid=1 data=9", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(11)) begin
      failures++;
      $display("FAIL bp_back_to_back valid=%0b data=%0h want valid=1 data=b", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== W'(11)) begin
      failures++;
      $display("FAIL bp_drop_valid valid=%0b data=%0h want valid=0 data=b", out_valid, out_data);
    end
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== drop0) begin
      failures++;
      $display("FAIL bp_drop_cnt got=%0d want=%0d", drop_cnt, drop0);
    end
`endif
  endtask

  task automatic test_supersede();
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    logic [7:0] drop0;
    drop0 = drop_cnt;
`endif
    out_ready = 1'b0;
    d_in = W'(3);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(3)) begin
      failures++;
      $display("FAIL sup_present3 valid=%0b data=%0h want valid=1 data=3", out_valid, out_data);
    end
    d_in = W'(4);
    for (int i = 0; i < 7; i++) tick();
    d_in = W'(6);
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(6)) begin
      failures++;
      $display("FAIL sup_deliver6 valid=%0b data=%0h want valid=1 data=6", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sup_no_repeat valid=%0b want=0", out_valid);
    end
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== drop0 + 8'd1) begin
      failures++;
      $display("FAIL sup_drop_cnt got=%0d want=%0d", drop_cnt, drop0 + 8'd1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    out_ready = 1'b0;
    d_in = W'(2);
    for (int i = 0; i < 7; i++) tick();
    d_in = W'(6);
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(6)) begin
      failures++;
      $display("FAIL rmid_setup valid=%0b data=%0h want valid=1 data=6", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL rmid_cleared valid=%0b data=%0h want valid=0 data=0", out_valid, out_data);
    end
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rmid_drop got=%0d want=0", drop_cnt);
    end
`endif
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_v = (i == 5);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== W'(6))) begin
        failures++;
        $display("FAIL rmid_represent edge=%0d valid=%0b data=%0h want valid=%0b data=6", i + 1, out_valid, out_data, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] val;
    int dur;
    int cyc;
    cyc = 0;
    while (cyc < 4000) begin
      val = W'($urandom_range(0, 3));
      dur = $urandom_range(1, 9);
      for (int k = 0; k < dur; k++) begin
        d_in = val;
        out_ready = ($urandom_range(0, 9) < 6);
        rst = ($urandom_range(0, 599) == 0);
        tick();
        cyc++;
        checks++;
        if ({out_valid, out_data} !== {m_valid, m_data}) begin
          failures++;
          $display("FAIL random_out cyc=%0d valid=%0b data=%0h want valid=%0b data=%0h", cyc, out_valid, out_data, m_valid, m_data);
        end
`ifdef SYNC_STABLE_CAPTURE_DROP_CNT_EN
        checks++;
        if (drop_cnt !== m_drop[7:0]) begin
          failures++;
          $display("FAIL random_drop cyc=%0d got=%0d want=%0d", cyc, drop_cnt, m_drop);
        end
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_zero();
    test_new_value();
    test_glitch();
    test_backpressure();
    test_supersede();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_stable_capture.md
Name: sync_stable_capture

Overview:
- Sits directly downstream of the 2-flop bus synchronizer. Consumes its synchronized output d_in, which may carry transient mixed-bit values while the source bus changes.
- Qualifies a value only after it has held unchanged for STABLE_CYCLES consecutive samples.
- Presents each new qualified value once on a valid/ready handshake to the consuming logic.

Parameters:
- DATA_WIDTH, 32, width of the synchronized bus and of out_data.
- STABLE_CYCLES, 4, number of consecutive matching samples needed to qualify a value. Legal range 1..255.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- d_in  input  DATA_WIDTH  synchronized bus from the synchronizer.
- out_data  output  DATA_WIDTH  qualified value; held stable while out_valid=1.
- out_valid  output  1  qualified value available.
- out_ready  input  1  consumer accepts out_data at a posedge where out_valid=1.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: out_data=0, out_valid=0. Internals: d_q=0, cnt=0, last_cap=0, first=1.
- Sample register: d_q<=d_in every edge.
- Counter, width $clog2(STABLE_CYCLES+1):
  - if d_in!=d_q: cnt<=0;
  - else cnt<=cnt+1, saturating at STABLE_CYCLES.
- stable = (cnt==STABLE_CYCLES), evaluated on registered state only.
- Capture condition at an edge: stable && (first || d_q!=last_cap) && (!out_valid || out_ready).
- On capture: out_data<=d_q, last_cap<=d_q, first<=0, out_valid<=1.
- Handshake: if out_valid && out_ready and no capture at that edge, out_valid<=0 the next cycle. out_data keeps its last value after valid drops.
- Back-to-back: handshake and capture at the same edge leave out_valid=1 with the new out_data. Zero-bubble.
- Blocked: out_valid=1 && !out_ready means no capture. The stable value stays in d_q/cnt and is captured on the first edge where out_ready=1, provided it is still stable.
- Superseded: if d_in changes while a qualified value is blocked, that value is lost; only the latest stable value is delivered.
- Duplicate suppression: a value equal to last_cap is never re-presented. This holds even after intermediate glitch values.
- First value after reset: always presented, including 0.
- Latency: value V first sampled at edge E0, unchanged at E1..EN (N=STABLE_CYCLES) gives cnt=N after EN, capture at E(N+1), out_valid=1 after E(N+1).
- STABLE_CYCLES=1: capture at E2.
- Glitch shorter than N+1 edges: never presented.
- Reset mid-operation: all state returns to reset values at that edge regardless of handshake. Any pending value is discarded.
- States, implied by (first, out_valid, stable):
  - IDLE: no value pending.
  - SETTLE: cnt<N.
  - QUALIFIED: stable, not yet captured.
  - PRESENT: out_valid=1.

Optional Feature:
- Macro: SYNC_STABLE_CAPTURE_DROP_CNT_EN.
- Defined: adds output port drop_cnt (output, 8 bits, reset 0). It increments, saturating at 255, at each edge where all of the following hold:
  - stable=1;
  - the value differs from last_cap (or first=1);
  - the capture is blocked by out_valid && !out_ready;
  - d_in!=d_q (the qualified value is being superseded).
- Not defined: port and logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset, out_ready=1, d_in held 0: out_valid rises after edge 5 following reset release (N=4), out_data=0. One transfer only; valid drops next cycle.
- d_in 0->5 before edge E0, held, out_ready=1: out_valid=1 after E5, out_data=5. Pulse is 1 cycle wide; no second transfer while 5 persists.
- Glitch: d_in 5->7 for 3 cycles then back to 5: no out_valid. 5->7 for 5 cycles then 5: two transfers, 7 then 5.
- Backpressure: out_ready=0, d_in=9 stable after 0x0 transfer held pending; d_in becomes 11 and stabilizes. On out_ready=1, 9 accepted, then 11 presented back-to-back with no bubble.
- Supersede with feature on: out_ready=0 while value 3 pending, values 4 then 6 each qualify and change. drop_cnt=1 (4 dropped); 6 is delivered after 3.
- Reset asserted while out_valid=1 and out_data=6: next cycle out_valid=0, out_data=0. After release, the first stable value (6) is re-presented.
